traffic_timing_sched: RTL and testbench
=======================================

// Module: traffic_timing_sched
// PURPOSE
// Schedules the traffic-light FSM. It sets the FSM's traffic_sel and red/green durations from a per-flow-level timing table.
// - Debounces the flow level from the image-processing path; falls back to a safe level when vision goes stale.
// - Commits each new plan only at phase boundaries, so durations never change while the FSM is counting them.
// - Exports a phase countdown for the VGA overlay.
// PARAMETERS
// CW            5      duration/counter width (seconds)
// CONFIRM_N     3      consecutive identical valid vis samples needed to accept a new level
// STALE_SEC     10     tick_sec periods without a valid vis sample before fallback
// FALLBACK_LVL  2'd1   level forced when stale
// DEF_RED0/1/2  5/8/12 reset red duration for levels 0/1/2
// DEF_GRN0/1/2  12/8/5 reset green duration for levels 0/1/2
// PORTS
// clk                 in   1   system clock
// reset_n             in   1   asynchronous active-low reset
// tick_sec            in   1   1-cycle second tick
// vis_valid           in   1   vis_level sample strobe
// vis_level           in   2   flow level 0..2; 3 = invalid, treated as no sample
// tr_valid            in   1   FSM pulse: first cycle of RED (new cycle started)
// light_valid         in   1   FSM pulse: first cycle of RED and first cycle of GREEN
// cfg_we              in   1   table write strobe
// cfg_idx             in   2   table entry 0..2; 3 = illegal
// cfg_red, cfg_green  in   CW  durations to write
// traffic_sel         out  2   committed level to FSM
// howmany_count_red   out  CW  red duration to FSM
// howmany_count_green out  CW  green duration to FSM
// remain_sec          out  CW  seconds left in current phase (display)
// phase_green         out  1   tracked phase: 1 = GREEN
// stale               out  1   vision stale; fallback active
// cfg_pending         out  1   shadow table differs from active table (write not yet applied)
// cfg_err             out  1   1-cycle pulse on cfg_we with cfg_idx==3
// BEHAVIOUR
// - Reset values:
//   - traffic_sel = 0, howmany_count_red = DEF_RED0, howmany_count_green = DEF_GRN0, plan_green = DEF_GRN0
//   - remain_sec = 0, phase_green = 0, stale = 0, cfg_pending = 0, cfg_err = 0
//   - Filter level lvl_q = 0, run count = 0. Shadow and active tables = DEF_*.
// - Level filter:
//   - On vis_valid with vis_level != 3: if it equals the candidate, run++ (saturate at CONFIRM_N), else candidate = vis_level and run = 1.
//   - When run reaches CONFIRM_N, lvl_q <= candidate (1-cycle latency).
//   - Any accepted sample clears the stale second counter and stale.
// - Watchdog:
//   - The stale counter increments on tick_sec.
//   - When it reaches STALE_SEC: stale <= 1, lvl_q <= FALLBACK_LVL, run cleared; the counter holds.
//   - A vis_valid sample and tick_sec in the same cycle: the sample wins and the counter is cleared.
// - Phase tracker states: WAIT (after reset), RED, GREEN.
//   - tr_valid -> RED from any state.
//   - light_valid && !tr_valid while in RED -> GREEN.
//   - tr_valid has priority over light_valid.
//   - light_valid in WAIT or GREEN without tr_valid is ignored.
// - Commit:
//   - On RED->GREEN, at the next edge: traffic_sel <= lvl_q, howmany_count_red <= active[lvl_q].red, plan_green <= active[lvl_q].green.
//   - On tr_valid: howmany_count_green <= plan_green. The cycle's green always matches the level the FSM latched.
//   - howmany_count_red is never written in RED; howmany_count_green is never written in GREEN.
// - Config:
//   - cfg_we with cfg_idx < 3 writes the shadow entry and sets cfg_pending.
//   - On tr_valid: active <= shadow, cfg_pending <= 0.
//   - A write coinciding with tr_valid lands in shadow and leaves cfg_pending = 1; the copy uses pre-write shadow.
//   - Illegal cfg_idx: no write, cfg_err pulses.
// - remain_sec:
//   - On entering RED, load the new green's partner red duration, i.e. howmany_count_red.
//   - On entering GREEN, load howmany_count_green.
//   - Otherwise decrement on tick_sec, saturating at 0.
//   - Zero durations are legal; the load wins over a same-cycle tick.
// - reset_n asserted mid-cycle: all state returns to reset values immediately. The tracker restarts in WAIT and resynchronises on the next tr_valid.
// - All arithmetic is unsigned CW bits; counters saturate and never wrap.
// STRUCTURE
// - Shared package traffic_pkg: typedef logic [1:0] level_t; enum {PH_WAIT, PH_RED, PH_GREEN} phase_t;
//   struct timing_t {red, green}; LVL_INVALID = 2'd3.
// - Sub-module traffic_level_filter: debounce plus stale watchdog; outputs lvl_q and stale.
// - Table, commit, tracker and countdown stay in the top module.
// TESTING
// - Reset, then tr_valid, then light_valid 6 cycles later -> phase_green = 1. traffic_sel stays 0 until commit, howmany_count_red = 5, remain_sec loads 12.
// - vis_level = 2 on 3 vis_valid strobes -> lvl_q = 2. At the next GREEN entry: traffic_sel = 2, red = 12. At the next tr_valid: green = 5.
// - vis_level sequence 2,2,1,2,2 -> no level change (run restarts). vis_level = 3 x5 -> ignored.
// - No vis_valid for 10 tick_sec -> stale = 1, level 1 committed at the next GREEN entry (red = 8, green = 8).
//   A later valid sample clears stale.
// - cfg_we idx = 0, red = 20, during GREEN -> cfg_pending = 1. Outputs unchanged until tr_valid; then cfg_pending = 0 and the next commit uses 20.
//   cfg_idx = 3 -> cfg_err pulse, no change.
// - tr_valid and light_valid in the same cycle -> tracker enters RED, not GREEN.
//   reset_n low mid-GREEN -> all outputs return to reset values.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light timing scheduler.
//   level_t     flow level 0..2, 3 marks an invalid vision sample
//   phase_t     tracked light phase
//   timing_t    red/green duration pair for one flow level
package traffic_pkg;

   localparam int CW = 5;

   typedef logic [1:0] level_t;

   localparam level_t LVL_INVALID = 2'd3;

   typedef enum logic [1:0] {
      PH_WAIT  = 2'd0,
      PH_RED   = 2'd1,
      PH_GREEN = 2'd2
   } phase_t;

   typedef struct packed {
      logic [CW-1:0] red;
      logic [CW-1:0] green;
   } timing_t;

endpackage

// File: rtl/traffic_level_filter.sv
// Debounces the flow level coming from the vision path and falls back to a
// safe level when no valid sample has arrived for STALE_SEC seconds.
//   clk, reset_n           clock, async active-low reset
//   tick_sec               1-cycle second tick
//   vis_valid, vis_level   vision sample strobe and level (3 = no sample)
//   lvl_q                  accepted level
//   stale                  vision stale, lvl_q forced to FALLBACK_LVL
module traffic_level_filter
   import traffic_pkg::*;
#(
   parameter int     CONFIRM_N    = 3,
   parameter int     STALE_SEC    = 10,
   parameter level_t FALLBACK_LVL = 2'd1
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   tick_sec,
   input  logic   vis_valid,
   input  level_t vis_level,
   output level_t lvl_q,
   output logic   stale
);

   localparam int RW = $clog2(CONFIRM_N + 1);
   localparam int SW = $clog2(STALE_SEC + 1);

   level_t        cand;
   logic [RW-1:0] run;
   logic [RW-1:0] run_nxt;
   logic [SW-1:0] stale_left;
   logic          sample;

   always_comb begin
      sample  = vis_valid && (vis_level != LVL_INVALID);
      run_nxt = RW'(1);
      if (vis_level == cand) begin
         run_nxt = (run == RW'(CONFIRM_N)) ? run : run + RW'(1);
      end
   end

   // Watchdog is a down-counter: reloaded by every accepted sample, and the
   // terminal count forces the fallback level once. It then holds at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cand       <= '0;
         run        <= '0;
         lvl_q      <= '0;
         stale      <= 1'b0;
         stale_left <= SW'(STALE_SEC);
      end else if (sample) begin
         cand       <= vis_level;
         run        <= run_nxt;
         stale      <= 1'b0;
         stale_left <= SW'(STALE_SEC);
         if (run_nxt == RW'(CONFIRM_N)) begin
            lvl_q <= vis_level;
         end
      end else if (tick_sec && (stale_left != '0)) begin
         stale_left <= stale_left - SW'(1);
         if (stale_left == SW'(1)) begin
            stale <= 1'b1;
            lvl_q <= FALLBACK_LVL;
            run   <= '0;
         end
      end
   end

endmodule

// File: rtl/traffic_timing_sched.sv
// Feeds the traffic-light FSM its level and red/green durations from a
// per-level timing table, committing new plans only at phase boundaries,
// and exports a per-phase seconds countdown for the display.
//   clk, reset_n                     clock, async active-low reset
//   tick_sec                         1-cycle second tick
//   vis_valid, vis_level             vision flow-level samples
//   tr_valid, light_valid            FSM phase-start pulses
//   cfg_we, cfg_idx, cfg_red/green   shadow table write port
//   traffic_sel, howmany_count_*     committed plan to the FSM
//   remain_sec, phase_green          display countdown and tracked phase
//   stale, cfg_pending, cfg_err      status
//
// state    | meaning
// PH_WAIT  | after reset, phase unknown until the first tr_valid
// PH_RED   | FSM counting red
// PH_GREEN | FSM counting green
module traffic_timing_sched
   import traffic_pkg::*;
#(
   parameter int            CONFIRM_N    = 3,
   parameter int            STALE_SEC    = 10,
   parameter level_t        FALLBACK_LVL = 2'd1,
   parameter logic [CW-1:0] DEF_RED0     = 5'd5,
   parameter logic [CW-1:0] DEF_RED1     = 5'd8,
   parameter logic [CW-1:0] DEF_RED2     = 5'd12,
   parameter logic [CW-1:0] DEF_GRN0     = 5'd12,
   parameter logic [CW-1:0] DEF_GRN1     = 5'd8,
   parameter logic [CW-1:0] DEF_GRN2     = 5'd5
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          tick_sec,
   input  logic          vis_valid,
   input  level_t        vis_level,
   input  logic          tr_valid,
   input  logic          light_valid,
   input  logic          cfg_we,
   input  logic [1:0]    cfg_idx,
   input  logic [CW-1:0] cfg_red,
   input  logic [CW-1:0] cfg_green,
   output level_t        traffic_sel,
   output logic [CW-1:0] howmany_count_red,
   output logic [CW-1:0] howmany_count_green,
   output logic [CW-1:0] remain_sec,
   output logic          phase_green,
   output logic          stale,
   output logic          cfg_pending,
   output logic          cfg_err
);

   level_t        lvl_q;
   phase_t        phase, phase_nxt;
   logic          enter_red, enter_green, commit_pend;
   logic [CW-1:0] plan_green;
   timing_t       shadow [3];
   timing_t       active [3];
   timing_t       sel_timing;

   traffic_level_filter #(
      .CONFIRM_N   (CONFIRM_N),
      .STALE_SEC   (STALE_SEC),
      .FALLBACK_LVL(FALLBACK_LVL)
   ) u_filter (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick_sec (tick_sec),
      .vis_valid(vis_valid),
      .vis_level(vis_level),
      .lvl_q    (lvl_q),
      .stale    (stale)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) phase <= PH_WAIT;
      else          phase <= phase_nxt;
   end

   always_comb begin
      phase_nxt   = phase;
      enter_red   = 1'b0;
      enter_green = 1'b0;
      if (tr_valid) begin
         phase_nxt = PH_RED;
         enter_red = 1'b1;
      end else if (light_valid && (phase == PH_RED)) begin
         phase_nxt   = PH_GREEN;
         enter_green = 1'b1;
      end
   end

   assign phase_green = (phase == PH_GREEN);

   always_comb begin
      sel_timing = active[0];
      case (lvl_q)
         2'd1:    sel_timing = active[1];
         2'd2:    sel_timing = active[2];
         default: sel_timing = active[0];
      endcase
   end

   // A write in the same cycle as tr_valid lands in shadow after the copy,
   // so it stays pending until the following cycle start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow[0]   <= '{red: DEF_RED0, green: DEF_GRN0};
         shadow[1]   <= '{red: DEF_RED1, green: DEF_GRN1};
         shadow[2]   <= '{red: DEF_RED2, green: DEF_GRN2};
         active[0]   <= '{red: DEF_RED0, green: DEF_GRN0};
         active[1]   <= '{red: DEF_RED1, green: DEF_GRN1};
         active[2]   <= '{red: DEF_RED2, green: DEF_GRN2};
         cfg_pending <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         if (tr_valid) begin
            for (int i = 0; i < 3; i++) active[i] <= shadow[i];
            cfg_pending <= 1'b0;
         end
         cfg_err <= 1'b0;
         if (cfg_we) begin
            case (cfg_idx)
               2'd0:    shadow[0] <= '{red: cfg_red, green: cfg_green};
               2'd1:    shadow[1] <= '{red: cfg_red, green: cfg_green};
               2'd2:    shadow[2] <= '{red: cfg_red, green: cfg_green};
               default: cfg_err   <= 1'b1;
            endcase
            if (cfg_idx != LVL_INVALID) cfg_pending <= 1'b1;
         end
      end
   end

   // Red plan is committed one edge into GREEN and green is handed over on
   // the next cycle start, so neither changes while the FSM is counting it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         commit_pend         <= 1'b0;
         traffic_sel         <= '0;
         howmany_count_red   <= DEF_RED0;
         howmany_count_green <= DEF_GRN0;
         plan_green          <= DEF_GRN0;
         remain_sec          <= '0;
      end else begin
         commit_pend <= enter_green;
         if (commit_pend) begin
            traffic_sel       <= lvl_q;
            howmany_count_red <= sel_timing.red;
            plan_green        <= sel_timing.green;
         end
         if (tr_valid) howmany_count_green <= plan_green;

         if (enter_red)                       remain_sec <= howmany_count_red;
         else if (enter_green)                remain_sec <= howmany_count_green;
         else if (tick_sec && remain_sec != '0) remain_sec <= remain_sec - CW'(1);
      end
   end

endmodule

// File: tb/tb_traffic_timing_sched.sv
module tb_traffic_timing_sched;
   import traffic_pkg::*;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          tick_sec, vis_valid, tr_valid, light_valid, cfg_we;
   logic [1:0]    vis_level, cfg_idx;
   logic [4:0]    cfg_red, cfg_green;
   logic [1:0]    traffic_sel;
   logic [4:0]    howmany_count_red, howmany_count_green, remain_sec;
   logic          phase_green, stale, cfg_pending, cfg_err;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      string       name;
      logic        tr, lv, vv;
      logic [1:0]  vl;
      logic        tk, we;
      logic [1:0]  idx;
      logic [4:0]  cr, cg;
      bit          chk;
      logic [20:0] exp;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   traffic_timing_sched dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .tick_sec           (tick_sec),
      .vis_valid          (vis_valid),
      .vis_level          (vis_level),
      .tr_valid           (tr_valid),
      .light_valid        (light_valid),
      .cfg_we             (cfg_we),
      .cfg_idx            (cfg_idx),
      .cfg_red            (cfg_red),
      .cfg_green          (cfg_green),
      .traffic_sel        (traffic_sel),
      .howmany_count_red  (howmany_count_red),
      .howmany_count_green(howmany_count_green),
      .remain_sec         (remain_sec),
      .phase_green        (phase_green),
      .stale              (stale),
      .cfg_pending        (cfg_pending),
      .cfg_err            (cfg_err)
   );

   always #5 clk = ~clk;

   function automatic logic [20:0] pk(int sel, int red, int grn, int rem,
                                      bit pg, bit st, bit pd, bit er);
      pk = {sel[1:0], red[4:0], grn[4:0], rem[4:0], pg, st, pd, er};
   endfunction

   task automatic add(string nm, logic tr, logic lv, logic vv, logic [1:0] vl,
                      logic tk, logic we, logic [1:0] idx, logic [4:0] cr,
                      logic [4:0] cg, bit chk, logic [20:0] e);
      vec_t v;
      v.name = nm; v.tr = tr; v.lv = lv; v.vv = vv; v.vl = vl; v.tk = tk;
      v.we = we; v.idx = idx; v.cr = cr; v.cg = cg; v.chk = chk; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic nop(int n);
      for (int i = 0; i < n; i++) add("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
   endtask

   task automatic vis(logic [1:0] l, int n);
      for (int i = 0; i < n; i++) add("vis", 0, 0, 1, l, 0, 0, 0, 0, 0, 0, '0);
   endtask

   task automatic tick(int n);
      for (int i = 0; i < n; i++) add("tick", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, '0);
   endtask

   task automatic drive(vec_t v);
      tr_valid = v.tr; light_valid = v.lv; vis_valid = v.vv; vis_level = v.vl;
      tick_sec = v.tk; cfg_we = v.we; cfg_idx = v.idx;
      cfg_red = v.cr; cfg_green = v.cg;
   endtask

   task automatic check(string nm, logic [20:0] e);
      logic [20:0] a;
      a = {traffic_sel, howmany_count_red, howmany_count_green, remain_sec,
           phase_green, stale, cfg_pending, cfg_err};
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got sel=%0d red=%0d grn=%0d rem=%0d pg=%b st=%b pd=%b er=%b, want sel=%0d red=%0d grn=%0d rem=%0d pg=%b st=%b pd=%b er=%b",
                  nm, a[20:19], a[18:14], a[13:9], a[8:4], a[3], a[2], a[1], a[0],
                  e[20:19], e[18:14], e[13:9], e[8:4], e[3], e[2], e[1], e[0]);
      end
   endtask

   task automatic run_vecs();
      vec_t v, e;
      while (vecs.size() > 0) begin
         v = vecs.pop_front();
         @(negedge clk);
         drive(v);
         sb.push_back(v);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         if (e.chk) check(e.name, e.exp);
      end
      @(negedge clk);
      v = '{name: "idle", default: '0};
      drive(v);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got no end, want end");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t idle_v;
      idle_v = '{name: "idle", default: '0};
      drive(idle_v);
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      //  name              tr lv vv vl tk we idx cr cg chk  sel red grn rem pg st pd er
      add("reset",          0, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(0,  5, 12,  0, 0, 0, 0, 0));
      add("lv_in_wait",     0, 1, 0, 0, 0, 0, 0, 0, 0, 1, pk(0,  5, 12,  0, 0, 0, 0, 0));
      add("tr_first",       1, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(0,  5, 12,  5, 0, 0, 0, 0));
      nop(5);
      add("enter_green",    0, 1, 0, 0, 0, 0, 0, 0, 0, 1, pk(0,  5, 12, 12, 1, 0, 0, 0));
      add("commit_lvl0",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(0,  5, 12, 12, 1, 0, 0, 0));
      add("tick_dec",       0, 0, 0, 0, 1, 0, 0, 0, 0, 1, pk(0,  5, 12, 11, 1, 0, 0, 0));
      vis(2, 3);
      add("lvl2_uncommit",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(0,  5, 12, 11, 1, 0, 0, 0));
      add("tr2",            1, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(0,  5, 12,  5, 0, 0, 0, 0));
      add("green2",         0, 1, 0, 0, 0, 0, 0, 0, 0, 1, pk(0,  5, 12, 12, 1, 0, 0, 0));
      add("commit_lvl2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(2, 12, 12, 12, 1, 0, 0, 0));
      add("tr3_green5",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(2, 12,  5, 12, 0, 0, 0, 0));
      vis(1, 2); vis(0, 1); vis(1, 2);
      vis(3, 5);
      add("green3",         0, 1, 0, 0, 0, 0, 0, 0, 0, 1, pk(2, 12,  5,  5, 1, 0, 0, 0));
      add("no_lvl_change",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(2, 12,  5,  5, 1, 0, 0, 0));
      vis(1, 1);
      add("tr4",            1, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(2, 12,  5, 12, 0, 0, 0, 0));
      add("green4",         0, 1, 0, 0, 0, 0, 0, 0, 0, 1, pk(2, 12,  5,  5, 1, 0, 0, 0));
      add("commit_lvl1",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(1,  8,  5,  5, 1, 0, 0, 0));
      add("tr5",            1, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(1,  8,  8,  8, 0, 0, 0, 0));
      vis(0, 3);
      tick(8);
      add("rem_saturate",   0, 0, 0, 0, 1, 0, 0, 0, 0, 1, pk(1,  8,  8,  0, 0, 0, 0, 0));
      add("stale_set",      0, 0, 0, 0, 1, 0, 0, 0, 0, 1, pk(1,  8,  8,  0, 0, 1, 0, 0));
      add("green_stale",    0, 1, 0, 0, 0, 0, 0, 0, 0, 1, pk(1,  8,  8,  8, 1, 1, 0, 0));
      add("commit_fallbk",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(1,  8,  8,  8, 1, 1, 0, 0));
      add("stale_clear",    0, 0, 1, 2, 0, 0, 0, 0, 0, 1, pk(1,  8,  8,  8, 1, 0, 0, 0));
      add("cfg_write",      0, 0, 0, 0, 0, 1, 0,20, 7, 1, pk(1,  8,  8,  8, 1, 0, 1, 0));
      add("cfg_illegal",    0, 0, 0, 0, 0, 1, 3,31,31, 1, pk(1,  8,  8,  8, 1, 0, 1, 1));
      add("cfg_err_clear",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(1,  8,  8,  8, 1, 0, 1, 0));
      vis(0, 3);
      add("tr_apply_cfg",   1, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(1,  8,  8,  8, 0, 0, 0, 0));
      add("green_cfg",      0, 1, 0, 0, 0, 0, 0, 0, 0, 1, pk(1,  8,  8,  8, 1, 0, 0, 0));
      add("commit_cfg20",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(0, 20,  8,  8, 1, 0, 0, 0));
      add("tr_lv_same",     1, 1, 0, 0, 0, 0, 0, 0, 0, 1, pk(0, 20,  7, 20, 0, 0, 0, 0));
      add("cfg_at_tr",      1, 0, 0, 0, 0, 1, 1, 9, 9, 1, pk(0, 20,  7, 20, 0, 0, 1, 0));
      add("green_pre_rst",  0, 1, 0, 0, 0, 0, 0, 0, 0, 1, pk(0, 20,  7,  7, 1, 0, 1, 0));
      run_vecs();

      // Asynchronous reset in the middle of GREEN: outputs must drop at once.
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("async_reset", pk(0, 5, 12, 0, 0, 0, 0, 0));
      @(negedge clk);
      reset_n = 1'b1;

      add("lv_after_rst",   0, 1, 0, 0, 0, 0, 0, 0, 0, 1, pk(0,  5, 12,  0, 0, 0, 0, 0));
      add("resync_tr",      1, 0, 0, 0, 0, 0, 0, 0, 0, 1, pk(0,  5, 12,  5, 0, 0, 0, 0));
      add("resync_green",   0, 1, 0, 0, 0, 0, 0, 0, 0, 1, pk(0,  5, 12, 12, 1, 0, 0, 0));
      run_vecs();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
